iter_cmp_unit: RTL and testbench

//  Multi-cycle, parametrised branch/set comparator for the pipelined MIPS core.

---
 rtl/cmp_pkg.sv | 47 ++++
 rtl/cmp_slice.sv | 14 +
 rtl/iter_cmp_unit.sv | 149 ++++++++++++++
 tb/tb_iter_cmp_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings and helpers for the iterative slice comparator.
package cmp_pkg;

  typedef enum logic [2:0] {
    CMP_OP_EQ  = 3'd0,
    CMP_OP_NE  = 3'd1,
    CMP_OP_LT  = 3'd2,
    CMP_OP_GE  = 3'd3,
    CMP_OP_LEZ = 3'd4,
    CMP_OP_GTZ = 3'd5,
    CMP_OP_LTZ = 3'd6,
    CMP_OP_GEZ = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } cmp_state_e;

  // Zero-ops occupy the upper half of the opcode space.
  function automatic logic is_zero_op(logic [2:0] op);
    return op[2];
  endfunction

  // Biasing the sign bit turns a signed compare into an unsigned one.
  function automatic logic sign_flip(logic msb, logic en);
    return msb ^ en;
  endfunction

  function automatic logic eval_cond(cmp_op_e op, logic gt, logic lt, logic eq);
    logic res;
    case (op)
      CMP_OP_EQ:  res = eq;
      CMP_OP_NE:  res = ~eq;
      CMP_OP_LT:  res = lt;
      CMP_OP_GE:  res = ~lt;
      CMP_OP_LEZ: res = ~gt;
      CMP_OP_GTZ: res = gt;
      CMP_OP_LTZ: res = lt;
      CMP_OP_GEZ: res = ~lt;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned magnitude compare of one operand slice.
module cmp_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/iter_cmp_unit.sv
// Multi-cycle MSB-first slice comparator with early exit and valid/ready on both sides.
module iter_cmp_unit
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_large,
  output logic             out_little,
  output logic             out_equal,
  output logic             out_zero
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NSLICE - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : gen_bad_chunk
    $error("iter_cmp_unit: WIDTH must be a non-zero multiple of CHUNK");
  end

  cmp_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  cmp_op_e         op_q, op_d;
  logic            signed_q, signed_d;
  logic            zero_q, zero_d;
  logic            gt_q, gt_d, lt_q, lt_d, eq_q, eq_d, result_q, result_d;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK-1:0] sa, sb, sx, sy;
  logic             sl_gt, sl_lt, flip;

  // Slice mux: shift keeps the select index width-agnostic.
  always_comb begin
    a_shift = a_q >> (32'(idx_q) * CHUNK);
    b_shift = b_q >> (32'(idx_q) * CHUNK);
    sa      = a_shift[CHUNK-1:0];
    sb      = b_shift[CHUNK-1:0];
    flip    = signed_q && (idx_q == IDX_MSB);
    sx      = sa;
    sy      = sb;
    sx[CHUNK-1] = sign_flip(sa[CHUNK-1], flip);
    sy[CHUNK-1] = sign_flip(sb[CHUNK-1], flip);
  end

  cmp_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .x  (sx),
    .y  (sy),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  assign in_ready = (state_q == StIdle) && !flush;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    signed_d = signed_q;
    zero_d   = zero_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_d      = in_a;
          b_d      = is_zero_op(in_op) ? '0 : in_b;
          op_d     = cmp_op_e'(in_op);
          signed_d = in_signed | is_zero_op(in_op);
          zero_d   = ~|in_a;
          idx_d    = IDX_MSB;
          state_d  = StScan;
        end
      end
      StScan: begin
        zero_d = zero_q & ~|sa;
        if (sl_gt || sl_lt || idx_q == '0) begin
          gt_d     = sl_gt;
          lt_d     = sl_lt;
          eq_d     = ~(sl_gt | sl_lt);
          result_d = eval_cond(op_q, sl_gt, sl_lt, ~(sl_gt | sl_lt));
          state_d  = StDone;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= CMP_OP_EQ;
      signed_q <= 1'b0;
      zero_q   <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      zero_q   <= zero_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      result_q <= result_d;
    end
  end

  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_large  = gt_q;
  assign out_little = lt_q;
  assign out_equal  = eq_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Scoreboard bench for iter_cmp_unit (32/8 instance plus a 16/16 single-slice instance).
module tb_iter_cmp_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_result, out_large, out_little, out_equal, out_zero;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] in_a16 = '0;
  logic [15:0] in_b16 = '0;
  logic [2:0]  in_op16 = '0;
  logic        in_signed16 = 1'b0;
  logic        out_valid16;
  logic        out_result16, out_large16, out_little16, out_equal16, out_zero16;
  logic        flush16 = 1'b0;
  logic        out_ready16 = 1'b1;

  iter_cmp_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_large(out_large),
    .out_little(out_little), .out_equal(out_equal), .out_zero(out_zero)
  );

  iter_cmp_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .flush(flush16), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .in_op(in_op16), .in_signed(in_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_result(out_result16),
    .out_large(out_large16), .out_little(out_little16), .out_equal(out_equal16),
    .out_zero(out_zero16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] flags;  // {result, large, little, equal, zero}
    int         k;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 2;  // 0 random, 1 stall, 2 always ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errs++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: whole-word arithmetic compare; k found by locating the top differing slice.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 input logic sgn, input int w, input int chunk);
    exp_t        e;
    logic [31:0] bb, d, mask;
    logic        zop, s, gt, lt, eq, res, found;
    int          ns, sh;
    zop = (op >= 3'd4);
    bb  = zop ? 32'd0 : b;
    s   = zop | sgn;
    sh  = 32 - w;
    eq  = (a == bb);
    if (s) begin
      gt = $signed(a << sh) > $signed(bb << sh);
      lt = $signed(a << sh) < $signed(bb << sh);
    end else begin
      gt = a > bb;
      lt = a < bb;
    end
    case (op)
      3'd0: res = eq;
      3'd1: res = !eq;
      3'd2: res = lt;
      3'd3: res = !lt;
      3'd4: res = !gt;
      3'd5: res = gt;
      3'd6: res = lt;
      default: res = !lt;
    endcase
    ns    = w / chunk;
    mask  = 32'((64'd1 << chunk) - 64'd1);
    d     = a ^ bb;
    e.k   = ns;
    found = 1'b0;
    for (int i = 0; i < ns; i++) begin
      if (!found && ((d >> ((ns - 1 - i) * chunk)) & mask) != 0) begin
        e.k   = i + 1;
        found = 1'b1;
      end
    end
    e.flags = {res, gt, lt, eq, (a == 32'd0)};
    e.acc   = 0;
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic sgn, input bit track);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_op = op; in_signed = sgn; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 200) begin
        timeout("accept_wait");
        in_valid = 1'b0;
        return;
      end
    end
    if (track) begin
      e     = model(a, b, op, sgn, 32, 8);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0) begin
      @(negedge clk);
      if (++n > 500) begin
        timeout("drain");
        sbq.delete();
      end
    end
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom % 4) != 0;
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: pops one expectation per output handshake; checks latency and hold stability.
  initial begin
    bit         seen;
    logic [4:0] snap, o;
    seen = 0;
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        o = {out_result, out_large, out_little, out_equal, out_zero};
        if (sbq.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            snap = o;
            check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].k));
            check("flags", 32'(o), 32'(sbq[0].flags));
          end else begin
            check("hold_stable", 32'(o), 32'(snap));
          end
          check("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(sbq.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    exp_t        e;
    int          m, j, vcount;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({out_valid, out_result, out_large, out_little, out_equal, out_zero}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed cases.
    issue(32'h1234_5678, 32'h1234_5678, 3'd0, 1'b0, 1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b1, 1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, 1);
    issue(32'h0000_0000, 32'hDEAD_BEEF, 3'd5, 1'b0, 1);
    issue(32'h0000_0000, 32'hDEAD_BEEF, 3'd7, 1'b0, 1);
    drain();

    // Consumer stall in DONE, then release.
    rdy_mode = 1;
    issue(32'h8000_0000, 32'h7FFF_FFFF, 3'd3, 1'b1, 1);
    vcount = 0;
    while (!out_valid && vcount < 20) begin
      @(negedge clk);
      vcount++;
    end
    if (!out_valid) timeout("stall_valid");
    repeat (5) @(negedge clk);
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    drain();

    // Flush during the second SCAN cycle.
    issue(32'hA5A5_5A5A, 32'hA5A5_5A5A, 3'd0, 1'b0, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'({in_ready, out_valid}), 32'b10);
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("flush_no_valid", 32'(vcount), 32'd0);

    // Flush together with in_valid in IDLE must not accept.
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2; in_op = 3'd2;
    @(negedge clk);
    check("flush_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept", 32'(in_ready), 32'd1);

    // Leave non-zero flags behind, then reset in the middle of a scan.
    issue(32'h0000_0005, 32'h0000_0003, 3'd3, 1'b0, 1);
    drain();
    issue(32'h5555_5555, 32'h5555_5555, 3'd0, 1'b0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_mid_scan",
          32'({out_valid, out_result, out_large, out_little, out_equal, out_zero}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("reset_discards", 32'({out_valid, in_ready}), 32'b01);

    // Randomised traffic with random back-pressure.
    rdy_mode = 0;
    for (int n = 0; n < 150; n++) begin
      m = $urandom_range(0, 3);
      j = $urandom_range(0, 3);
      a = $urandom;
      case (m)
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'($urandom_range(1, 255)) << (8 * j));
        default: begin a = 32'd0; b = $urandom; end
      endcase
      issue(a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
    end
    drain();
    rdy_mode = 2;

    // Single-slice instance: every op completes after one SCAN cycle.
    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      #1;
      in_a16 = 16'($urandom);
      in_b16 = ($urandom % 3 == 0) ? in_a16 : 16'($urandom);
      if (n % 5 == 4) in_a16 = 16'd0;
      in_op16 = 3'(n % 8);
      in_signed16 = 1'($urandom_range(0, 1));
      in_valid16 = 1'b1;
      e = model({16'd0, in_a16}, {16'd0, in_b16}, in_op16, in_signed16, 16, 16);
      @(negedge clk);
      check("w16_ready", 32'(in_ready16), 32'd1);
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      @(negedge clk);
      check("w16_not_yet", 32'(out_valid16), 32'd0);
      @(negedge clk);
      check("w16_one_cycle", 32'(out_valid16), 32'd1);
      check("w16_flags",
            32'({out_result16, out_large16, out_little16, out_equal16, out_zero16}),
            32'(e.flags));
    end
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
